ps2_keycode_rx: RTL and testbench

PS/2 keyboard receiver that turns the serial ps2_clk/ps2_data stream into the same 8-bit HID-style `keycode` the game logic already consumes from the USB path. It lets the ball and block state machine be driven with no Nios/USB stack. It runs in the 50 MHz system domain and sits beside the USB system as an alternative keycode source. It synchronises both PS/2 lines, deframes 11-bit frames, handles E0/F0 prefixes, and translates a fixed key subset.

---
 rtl/ps2_pkg.sv | 54 +++++
 rtl/ps2_keycode_rx_if.sv | 26 ++
 rtl/ps2_frame_rx.sv | 128 ++++++++++++
 rtl/ps2_keycode_rx.sv | 85 ++++++++
 tb/tb_ps2_keycode_rx.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types, constants and the scan-code to HID translation for the PS/2 receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  // Prefix bytes of the set-2 scan code stream.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // HID usage codes the game logic understands.
  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_ENTER = 8'h28;
  localparam logic [7:0] HID_UP    = 8'h52;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_RIGHT = 8'h4F;

  // Map a scan code (with its E0 flag) to HID; anything outside the subset is HID_NONE.
  function automatic logic [7:0] translate(input logic ext, input logic [7:0] code);
    logic [7:0] hid;
    hid = HID_NONE;
    if (ext) begin
      case (code)
        8'h75:   hid = HID_UP;
        8'h72:   hid = HID_DOWN;
        8'h6B:   hid = HID_LEFT;
        8'h74:   hid = HID_RIGHT;
        default: hid = HID_NONE;
      endcase
    end else begin
      case (code)
        8'h1D:   hid = HID_W;
        8'h1C:   hid = HID_A;
        8'h1B:   hid = HID_S;
        8'h23:   hid = HID_D;
        8'h29:   hid = HID_SPACE;
        8'h5A:   hid = HID_ENTER;
        default: hid = HID_NONE;
      endcase
    end
    return hid;
  endfunction

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// Bundle of PS/2 pins and keycode outputs. The receiver is listen-only, so
// ps2_clk/ps2_data only ever flow from the keyboard side into the slave.
// key_valid and frame_err are single-cycle strobes with no ready: the consumer
// must accept every pulse in the cycle it appears.
interface ps2_keycode_rx_if;
  import ps2_pkg::*;

  logic         ps2_clk;
  logic         ps2_data;
  logic [7:0]   keycode;
  logic         key_valid;
  logic [7:0]   scan_code;
  logic         frame_err;
  frame_state_t dbg_state;

  modport master (
    output ps2_clk, ps2_data,
    input  keycode, key_valid, scan_code, frame_err, dbg_state
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keycode, key_valid, scan_code, frame_err, dbg_state
  );

endinterface

// File: rtl/ps2_frame_rx.sv
// Synchronises the PS/2 lines and deframes 11-bit frames (start, 8 data LSB first,
// odd parity, stop) into bytes, flagging parity/stop errors and mid-frame timeouts.
import ps2_pkg::*;

module ps2_frame_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [7:0]   rx_byte,
  output logic         byte_done,
  output logic         frame_err,
  output logic         timeout,
  output frame_state_t state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          fall;
  logic          data_bit;
  frame_state_t  state_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [CW-1:0] to_cnt;
  logic          to_hit;
  logic          shift_en;
  logic          parity_en;
  logic          frame_ok;
  logic          frame_bad;

  // Two-flop synchronisers, idle-high; the third clock flop gives the edge detector its history.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall     = !clk_sync[1] && clk_sync[2];
  assign data_bit = data_sync[1];

  // A falling edge in the terminal cycle keeps the frame alive.
  assign to_hit = (state != IDLE) && !fall && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Gap counter between PS/2 clock edges while a frame is in progress.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      to_cnt <= '0;
    end else if (fall || to_hit || (state == IDLE)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + CW'(1);
    end
  end

  // Frame state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame sequencing on each sampling strobe; a timeout aborts to IDLE.
  always_comb begin
    state_next = state;
    if (to_hit) begin
      state_next = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!data_bit) state_next = DATA;
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Per-state actions decoded from the current state and strobe.
  always_comb begin
    shift_en  = fall && (state == DATA);
    parity_en = fall && (state == PARITY);
    frame_ok  = fall && (state == STOP) && data_bit && (^{shift_reg, parity_bit});
    frame_bad = (fall && (state == STOP) && !frame_ok) || to_hit;
  end

  // Datapath: bit counter, shift register, parity capture and registered results.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      parity_bit <= 1'b0;
      rx_byte    <= 8'h00;
      byte_done  <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (fall && (state == IDLE)) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_en) begin
        shift_reg <= {data_bit, shift_reg[7:1]};
      end
      if (parity_en) begin
        parity_bit <= data_bit;
      end
      if (frame_ok) begin
        rx_byte <= shift_reg;
      end
      byte_done <= frame_ok;
      frame_err <= frame_bad;
      timeout   <= to_hit;
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard to HID keycode source: deframes scan codes, tracks E0/F0 prefixes
// and publishes the currently held key from a fixed translation subset.
import ps2_pkg::*;

module ps2_keycode_rx #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TIMEOUT_US = 200
) (
  input  logic             Clk,
  input  logic             Reset,
  ps2_keycode_rx_if.slave  bus
);

  localparam int unsigned TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;

  logic [7:0]   rx_byte;
  logic         byte_done;
  logic         frame_err;
  logic         timeout;
  frame_state_t state;
  logic         ext_pending;
  logic         brk_pending;
  logic [7:0]   keycode;
  logic         key_valid;
  logic [7:0]   code;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame (
    .Clk       (Clk),
    .Reset     (Reset),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .rx_byte   (rx_byte),
    .byte_done (byte_done),
    .frame_err (frame_err),
    .timeout   (timeout),
    .state     (state)
  );

  assign code = translate(ext_pending, rx_byte);

  // Prefix tracking and held-key update; a break only releases the key that is held.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
      keycode     <= 8'h00;
      key_valid   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (timeout) begin
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (byte_done) begin
        if (rx_byte == PS2_EXT) begin
          ext_pending <= 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk_pending <= 1'b1;
        end else begin
          ext_pending <= 1'b0;
          brk_pending <= 1'b0;
          if (code != HID_NONE) begin
            if (brk_pending) begin
              if (code == keycode) begin
                keycode   <= HID_NONE;
                key_valid <= 1'b1;
              end
            end else begin
              keycode   <= code;
              key_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.keycode   = keycode;
  assign bus.key_valid = key_valid;
  assign bus.scan_code = rx_byte;
  assign bus.frame_err = frame_err;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: directed scenarios plus randomized key traffic
// checked against a table-driven keyboard model.
module tb_ps2_keycode_rx;
  import ps2_pkg::*;

  localparam int HALF  = 15;     // system cycles per half PS/2 bit period
  localparam int T_CYC = 10000;  // 50 MHz * 200 us

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #10 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  ps2_keycode_rx_if bus ();

  ps2_keycode_rx #(
    .CLK_HZ     (50_000_000),
    .TIMEOUT_US (200)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;

  // ---------------- monitor ----------------
  logic [7:0]  got_q[$];
  int          kv_cnt = 0;
  int          fe_cnt = 0;
  int unsigned kv_cyc = 0;
  int unsigned fe_cyc = 0;
  int unsigned last_fall = 0;

  always @(negedge Clk) begin
    if (bus.key_valid === 1'b1) begin
      got_q.push_back(bus.keycode);
      kv_cnt++;
      kv_cyc = cyc;
    end
    if (bus.frame_err === 1'b1) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (bus.key_valid === 1'b1 && bus.frame_err === 1'b1) begin
      errors++;
      $display("FAIL pulse_overlap: key_valid=1 frame_err=1, required never both");
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] std_tab[256];
  logic [7:0] ext_tab[256];
  logic [7:0] exp_q[$];
  logic [7:0] m_keycode = 8'h00;
  logic [7:0] m_scan = 8'h00;
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;
  int         m_fe = 0;

  task automatic init_tables();
    for (int i = 0; i < 256; i++) begin
      std_tab[i] = 8'h00;
      ext_tab[i] = 8'h00;
    end
    std_tab[8'h1D] = 8'h1A; std_tab[8'h1C] = 8'h04; std_tab[8'h1B] = 8'h16;
    std_tab[8'h23] = 8'h07; std_tab[8'h29] = 8'h2C; std_tab[8'h5A] = 8'h28;
    ext_tab[8'h75] = 8'h52; ext_tab[8'h72] = 8'h51;
    ext_tab[8'h6B] = 8'h50; ext_tab[8'h74] = 8'h4F;
  endtask

  // What a keyboard host would do with one received frame.
  task automatic model_frame(input logic [7:0] b, input bit bad);
    logic [7:0] hid;
    bit         was_brk;
    if (bad) begin
      m_fe++;
      return;
    end
    m_scan = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      hid = m_ext ? ext_tab[b] : std_tab[b];
      was_brk = m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
      if (hid != 8'h00) begin
        if (!was_brk) begin
          m_keycode = hid;
          exp_q.push_back(hid);
        end else if (hid == m_keycode) begin
          m_keycode = 8'h00;
          exp_q.push_back(8'h00);
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b0;
    last_fall = cyc;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
    bus.ps2_data = 1'b1;
    wait_cyc(6);
  endtask

  task automatic xfer(input logic [7:0] b, input bit bad);
    send_frame(b, bad, 11);
    model_frame(b, bad);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vectors += 5;
    if (bus.keycode !== 8'h00) begin errors++; $display("FAIL reset_keycode: got %h need 00", bus.keycode); end
    if (bus.scan_code !== 8'h00) begin errors++; $display("FAIL reset_scan: got %h need 00", bus.scan_code); end
    if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b need 0", bus.key_valid); end
    if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b need 0", bus.frame_err); end
    if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d need IDLE", bus.dbg_state); end
  endtask

  task automatic test_make_latency();
    int kv0;
    kv0 = kv_cnt;
    xfer(8'h1D, 1'b0);
    vectors += 4;
    if (bus.scan_code !== 8'h1D) begin errors++; $display("FAIL w_scan: got %h need 1D", bus.scan_code); end
    if (bus.keycode !== 8'h1A) begin errors++; $display("FAIL w_keycode: got %h need 1A", bus.keycode); end
    if (kv_cnt - kv0 != 1) begin errors++; $display("FAIL w_pulses: got %0d need 1", kv_cnt - kv0); end
    if (kv_cyc - last_fall != 4) begin errors++; $display("FAIL w_latency: got %0d need 4", kv_cyc - last_fall); end
    xfer(8'hF0, 1'b0);
    xfer(8'h1D, 1'b0);
    vectors += 2;
    if (bus.keycode !== 8'h00) begin errors++; $display("FAIL w_release: got %h need 00", bus.keycode); end
    if (kv_cnt - kv0 != 2) begin errors++; $display("FAIL w_release_pulses: got %0d need 2", kv_cnt - kv0); end
  endtask

  task automatic test_extended();
    int kv0;
    kv0 = kv_cnt;
    got_q.delete();
    xfer(8'hE0, 1'b0);
    xfer(8'h75, 1'b0);
    vectors += 1;
    if (bus.keycode !== 8'h52) begin errors++; $display("FAIL up_make: got %h need 52", bus.keycode); end
    xfer(8'hE0, 1'b0);
    xfer(8'hF0, 1'b0);
    xfer(8'h75, 1'b0);
    vectors += 4;
    if (bus.keycode !== 8'h00) begin errors++; $display("FAIL up_break: got %h need 00", bus.keycode); end
    if (bus.scan_code !== 8'h75) begin errors++; $display("FAIL up_scan: got %h need 75", bus.scan_code); end
    if (kv_cnt - kv0 != 2) begin errors++; $display("FAIL up_pulses: got %0d need 2", kv_cnt - kv0); end
    if (got_q.size() != 2 || got_q[0] !== 8'h52 || got_q[1] !== 8'h00) begin
      errors++; $display("FAIL up_sequence: got %0d pulses, need 52 then 00", got_q.size());
    end
  endtask

  task automatic test_break_other();
    int kv0;
    kv0 = kv_cnt;
    xfer(8'h1C, 1'b0);
    xfer(8'hF0, 1'b0);
    xfer(8'h1D, 1'b0);
    vectors += 2;
    if (bus.keycode !== 8'h04) begin errors++; $display("FAIL other_break_keycode: got %h need 04", bus.keycode); end
    if (kv_cnt - kv0 != 1) begin errors++; $display("FAIL other_break_pulses: got %0d need 1", kv_cnt - kv0); end
  endtask

  task automatic test_parity();
    int kv0, fe0;
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    xfer(8'h23, 1'b1);
    vectors += 4;
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL parity_err: got %0d pulses need 1", fe_cnt - fe0); end
    if (bus.scan_code !== m_scan) begin errors++; $display("FAIL parity_scan: got %h need %h", bus.scan_code, m_scan); end
    if (bus.keycode !== m_keycode) begin errors++; $display("FAIL parity_keycode: got %h need %h", bus.keycode, m_keycode); end
    if (kv_cnt - kv0 != 0) begin errors++; $display("FAIL parity_pulses: got %0d need 0", kv_cnt - kv0); end
  endtask

  task automatic test_timeout();
    int fe0;
    int unsigned t0;
    xfer(8'hE0, 1'b0);
    fe0 = fe_cnt;
    send_frame(8'h29, 1'b0, 5);
    t0 = last_fall;
    wait_cyc(12500);
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_fe++;
    vectors += 2;
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL timeout_err: got %0d pulses need 1", fe_cnt - fe0); end
    if (fe_cyc - t0 < T_CYC || fe_cyc - t0 > T_CYC + 4) begin
      errors++; $display("FAIL timeout_time: got %0d cycles need %0d..%0d", fe_cyc - t0, T_CYC, T_CYC + 4);
    end
    xfer(8'h29, 1'b0);
    vectors += 2;
    if (bus.keycode !== 8'h2C) begin errors++; $display("FAIL timeout_recover: got %h need 2C", bus.keycode); end
    if (bus.scan_code !== 8'h29) begin errors++; $display("FAIL timeout_scan: got %h need 29", bus.scan_code); end
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h1B, 1'b0, 5);
    Reset = 1'b0;
    wait_cyc(3);
    Reset = 1'b1;
    m_keycode = 8'h00;
    m_scan = 8'h00;
    m_ext = 1'b0;
    m_brk = 1'b0;
    wait_cyc(20);
    vectors += 4;
    if (bus.keycode !== 8'h00) begin errors++; $display("FAIL rst_mid_keycode: got %h need 00", bus.keycode); end
    if (bus.scan_code !== 8'h00) begin errors++; $display("FAIL rst_mid_scan: got %h need 00", bus.scan_code); end
    if (fe_cnt != fe0) begin errors++; $display("FAIL rst_mid_err: got %0d pulses need 0", fe_cnt - fe0); end
    if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d need IDLE", bus.dbg_state); end
    xfer(8'h1B, 1'b0);
    vectors += 1;
    if (bus.keycode !== 8'h16) begin errors++; $display("FAIL rst_mid_next: got %h need 16", bus.keycode); end
  endtask

  task automatic test_random();
    logic [7:0] key_code[10];
    bit         key_ext[10];
    logic [7:0] odd_codes[4];
    logic [7:0] g, e;
    int         r, k;
    key_code = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74};
    key_ext  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    odd_codes = '{8'hAA, 8'hFA, 8'hEE, 8'hFE};
    got_q.delete();
    exp_q.delete();
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 6) begin
        k = $urandom_range(0, 9);
        if (key_ext[k]) xfer(8'hE0, 1'b0);
        if ($urandom_range(0, 2) == 0) xfer(8'hF0, 1'b0);
        xfer(key_code[k], 1'b0);
      end else if (r == 7) begin
        xfer(odd_codes[$urandom_range(0, 3)], 1'b0);
      end else if (r == 8) begin
        xfer(8'($urandom_range(0, 255)), 1'b0);
      end else begin
        xfer(8'($urandom_range(0, 255)), 1'b1);
      end
      vectors += 4;
      if (bus.keycode !== m_keycode) begin errors++; $display("FAIL rnd_keycode[%0d]: got %h need %h", n, bus.keycode, m_keycode); end
      if (bus.scan_code !== m_scan) begin errors++; $display("FAIL rnd_scan[%0d]: got %h need %h", n, bus.scan_code, m_scan); end
      if (fe_cnt != m_fe) begin errors++; $display("FAIL rnd_frame_err[%0d]: got %0d need %0d", n, fe_cnt, m_fe); end
      if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd_pulse_count[%0d]: got %0d need %0d", n, got_q.size(), exp_q.size());
        got_q.delete();
        exp_q.delete();
      end else begin
        while (exp_q.size() > 0) begin
          g = got_q.pop_front();
          e = exp_q.pop_front();
          vectors++;
          if (g !== e) begin errors++; $display("FAIL rnd_pulse_value[%0d]: got %h need %h", n, g, e); end
        end
      end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    init_tables();
    #5 Reset = 1'b0;
    wait_cyc(4);
    Reset = 1'b1;
    wait_cyc(4);
    test_reset();
    test_make_latency();
    test_extended();
    test_break_other();
    test_parity();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Run-time bound in case stimulus ever stalls.
  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

endmodule
